// File: rtl/exe_muldiv_pkg.sv
// Shared definitions for the EXE-stage multiply/divide unit.
//   md_op_e    : op-select encoding presented by the ID/EXE register
//                (the instruction decoder reuses the same encoding)
//   md_state_e : iteration FSM states
package exe_muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_FINISH = 2'b10
    } md_state_e;

    // op[1] selects divide, op[0] selects unsigned
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/exe_muldiv_core.sv
// Single-iteration datapath of the multiply/divide unit; purely combinational.
//   is_div  : 1 = restoring-divide step, 0 = shift-add multiply step
//   opnd    : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   rem_in  : upper accumulator half (multiply) or partial remainder (divide)
//   q_in    : multiplier / low product bits (multiply) or dividend / quotient
//   rem_out, q_out : accumulator after this iteration
module exe_muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] opnd,
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   shl_s;
    logic [WIDTH-1:0] diff_s;
    logic             ge_s;

    // One shift-add or one restoring-subtract step
    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set; the carry is kept in the extra bit and
        // shifted back in.
        if (q_in[0]) begin
            add_s = {1'b0, rem_in} + {1'b0, opnd};
        end else begin
            add_s = {1'b0, rem_in};
        end

        // Divide: shift the next dividend bit into the remainder. The shifted
        // value needs WIDTH+1 bits; when it is >= divisor the true difference
        // is below the divisor, so the low WIDTH bits of a modulo subtract
        // are exact.
        shl_s  = {rem_in, q_in[WIDTH-1]};
        ge_s   = (shl_s >= {1'b0, opnd});
        diff_s = shl_s[WIDTH-1:0] - opnd;

        if (is_div) begin
            if (ge_s) begin
                rem_out = diff_s;
                q_out   = {q_in[WIDTH-2:0], 1'b1};
            end else begin
                rem_out = shl_s[WIDTH-1:0];
                q_out   = {q_in[WIDTH-2:0], 1'b0};
            end
        end else begin
            rem_out = add_s[WIDTH:1];
            q_out   = {add_s[0], q_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/exe_muldiv.sv
// Iterative multiply/divide unit of the EXE stage, owner of HI/LO.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start, op     : mul/div instruction in EXE (level) and its op-select
//   rega, regb    : operand A (multiplicand/dividend), B (multiplier/divisor)
//   flush         : abort any running operation, block a new one
//   hi_we, lo_we, wdata : MTHI/MTLO writes, honoured only while idle
//   stall         : hold ID/EXE and upstream while the operation runs
//   busy, done    : unit in RUN/FINISH; one-cycle completion pulse
//   hi, lo        : architectural HI/LO registers
module exe_muldiv
    import exe_muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rega,
    input  logic [WIDTH-1:0] regb,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_e        state_r;
    logic [CNT_W-1:0] cnt_r;
    md_op_e           op_r;
    logic [WIDTH-1:0] opnd_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] q_r;
    logic             res_neg_r;
    logic             rem_neg_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    md_op_e           op_s;
    logic             go_s;
    logic             a_neg_s;
    logic             b_neg_s;
    logic             b_zero_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] core_rem_s;
    logic [WIDTH-1:0] core_q_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] res_hi_s;
    logic [WIDTH-1:0] res_lo_s;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
        return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitudes and signs; the magnitude of the most negative value
    // is 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
    always_comb begin
        op_s     = md_op_e'(op);
        go_s     = start & ~flush;
        a_neg_s  = op_is_signed(op) & rega[WIDTH-1];
        b_neg_s  = op_is_signed(op) & regb[WIDTH-1];
        b_zero_s = (regb == {WIDTH{1'b0}});
        if (a_neg_s) begin
            a_mag_s = neg_w(rega);
        end else begin
            a_mag_s = rega;
        end
        if (b_neg_s) begin
            b_mag_s = neg_w(regb);
        end else begin
            b_mag_s = regb;
        end
    end

    exe_muldiv_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .is_div  (op_is_div(op_r)),
        .opnd    (opnd_r),
        .rem_in  (rem_r),
        .q_in    (q_r),
        .rem_out (core_rem_s),
        .q_out   (core_q_s)
    );

    // Iteration FSM and working registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            op_r      <= MD_MULT;
            opnd_r    <= {WIDTH{1'b0}};
            rem_r     <= {WIDTH{1'b0}};
            q_r       <= {WIDTH{1'b0}};
            res_neg_r <= 1'b0;
            rem_neg_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (go_s) begin
                        state_r <= ST_RUN;
                        cnt_r   <= {CNT_W{1'b0}};
                        op_r    <= op_s;
                        rem_r   <= {WIDTH{1'b0}};
                        if (op_is_div(op)) begin
                            opnd_r    <= b_mag_s;
                            q_r       <= a_mag_s;
                            // divide by zero returns all-ones unnegated
                            res_neg_r <= (a_neg_s ^ b_neg_s) & ~b_zero_s;
                            rem_neg_r <= a_neg_s;
                        end else begin
                            opnd_r    <= a_mag_s;
                            q_r       <= b_mag_s;
                            res_neg_r <= a_neg_s ^ b_neg_s;
                            rem_neg_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        state_r <= ST_IDLE;
                    end else begin
                        rem_r <= core_rem_s;
                        q_r   <= core_q_s;
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (cnt_r == LAST_CNT) begin
                            state_r <= ST_FINISH;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                // start is still the retiring instruction here, never a new one
                ST_FINISH: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sign-corrected results from the final accumulator
    always_comb begin
        if (res_neg_r) begin
            prod_s = neg_2w({rem_r, q_r});
        end else begin
            prod_s = {rem_r, q_r};
        end
        case (op_r)
            MD_MULT, MD_MULTU: begin
                res_hi_s = prod_s[2*WIDTH-1:WIDTH];
                res_lo_s = prod_s[WIDTH-1:0];
            end
            MD_DIV, MD_DIVU: begin
                res_lo_s = res_neg_r ? neg_w(q_r) : q_r;
                res_hi_s = rem_neg_r ? neg_w(rem_r) : rem_r;
            end
            default: begin
                res_hi_s = {WIDTH{1'b0}};
                res_lo_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // HI/LO: MTHI/MTLO while idle, results at the end of FINISH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (state_r == ST_IDLE) begin
            if (hi_we) begin
                hi_r <= wdata;
            end
            if (lo_we) begin
                lo_r <= wdata;
            end
        end else if ((state_r == ST_FINISH) && !flush) begin
            hi_r <= res_hi_s;
            lo_r <= res_lo_s;
        end
    end

    // stall must drop in FINISH so the held instruction leaves EXE; it is
    // forced low during reset even if start is asserted.
    assign stall = rst_n & (((state_r == ST_IDLE) & go_s) | (state_r == ST_RUN));
    assign busy  = (state_r == ST_RUN) | (state_r == ST_FINISH);
    assign done  = (state_r == ST_FINISH) & ~flush;
    assign hi    = hi_r;
    assign lo    = lo_r;

endmodule

// File: doc/exe_muldiv.md
Name: exe_muldiv

Overview:
Iterative multiply/divide unit in the EXE stage. It consumes the operand and op-select fields that the ID/EXE pipeline register presents, and it owns the architectural HI/LO registers. While an operation runs it raises a stall, which is inverted into that register's EN so the instruction stays in EXE. It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO; MFHI/MFLO read the hi/lo outputs directly.

Parameters:
WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.
CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  EXE instruction is a mul/div op; level, held while the instruction stays in EXE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rega  in  WIDTH  operand A (dividend / multiplicand)
regb  in  WIDTH  operand B (divisor / multiplier)
flush  in  1  abort the current operation (exception/redirect)
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  WIDTH  MTHI/MTLO data
stall  out  1  hold the ID/EXE register and upstream stages
busy  out  1  unit is in RUN or FINISH
done  out  1  one-cycle pulse, asserted in the FINISH cycle
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0: state=IDLE, counter=0, hi=lo=0, stall=busy=done=0. Reset mid-operation discards the operation.
- FSM has three states: IDLE, RUN, FINISH.
- IDLE -> RUN when start=1 and flush=0:
  - latch operand magnitudes (signed ops: two's-complement absolute value), result sign, remainder sign, and op;
  - clear the accumulator; counter=0.
- RUN performs one iteration per cycle:
  - multiply: shift-add;
  - divide: restoring;
  - counter increments; after WIDTH iterations (counter==WIDTH-1) go to FINISH.
- FINISH:
  - write sign-corrected results: hi=product[2W-1:W], lo=product[W-1:0]; for divides, lo=quotient, hi=remainder;
  - done=1; return to IDLE unconditionally;
  - start is ignored here, because it is still the same held instruction leaving EXE.
- stall = (state==IDLE & start & ~flush) | (state==RUN). It is combinational and deasserts in FINISH, so the ID/EXE register advances at the end of FINISH.
- Latency from the start-sampling edge: stall is high for WIDTH+1 consecutive cycles; HI/LO are valid in the cycle after FINISH.
- busy = (state==RUN) | (state==FINISH).
- Signed results: the quotient is negative iff the operand signs differ; the remainder takes the dividend's sign. Operands of 0x80000000 are handled as magnitude 2^31, so the working registers are WIDTH+1 bits where needed.
- Divide by zero (DIV or DIVU with regb=0): no exception; full latency still applies; lo=all-ones, hi=rega.
- DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- flush in RUN or FINISH: go to IDLE next edge; hi/lo are not written; done=0. flush in IDLE blocks start.
- MTHI/MTLO:
  - hi_we/lo_we write in IDLE only; they are ignored in RUN and FINISH;
  - if hi_we and lo_we are both set, both registers are written;
  - start together with hi_we is an illegal encoding; hi_we takes effect and the operation still starts.
- hi/lo hold their value in every other case.

Decomposition:
- Shared package: op encodings (MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11) and FSM state encodings; the decoder reuses the op encodings.
- One natural sub-module: exe_muldiv_core, the single-iteration datapath (shift-add step / restoring-subtract step) with no state.
- FSM, sign handling and HI/LO live in exe_muldiv.

Test Plan:
- MULT rega=0xFFFFFFFD (-3), regb=5 -> stall high 33 cycles, done pulse once, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Separately, DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Separately, DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- DIVU 100/0 -> after 33 stall cycles lo=0xFFFFFFFF, hi=100; no other side effect.
- Back-to-back sequence DIVU 100/7 then MULTU 3x4 with start held as a level -> first result hi=2, lo=14; second starts in the cycle after FINISH; final hi=0, lo=12; exactly two done pulses.
- flush at RUN cycle 10 -> IDLE next edge, stall=0, hi/lo keep prior values (preload via MTHI 0x1234, MTLO 0x5678).
- rst_n low at RUN cycle 5 -> hi=lo=0, stall=busy=done=0 immediately, without waiting for a clock edge. Separately, hi_we during RUN -> hi unchanged.
